// File: rtl/mdu_defs_pkg.sv
// Shared MDU definitions: MDUop encodings, default latencies and scheduler state type.
// The divider is only built when MDU_DIV_EN is defined.
package mdu_defs;

  localparam logic [2:0] MDU_MULTU = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit {HI,LO} result and divide-by-zero flag.
// Division is compiled in only when MDU_DIV_EN is defined.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [2:0]  MDUop,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
  assign prod_u = {32'b0, rs_E} * {32'b0, rt_E};

`ifdef MDU_DIV_EN
  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Divide magnitudes, then restore signs; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
  always_comb begin
    is_signed = (MDUop == MDU_DIV);
    a_mag     = (is_signed && rs_E[31]) ? (32'd0 - rs_E) : rs_E;
    b_mag     = (is_signed && rt_E[31]) ? (32'd0 - rt_E) : rt_E;
    q_mag     = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag     = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    quot      = (is_signed && (rs_E[31] ^ rt_E[31])) ? (32'd0 - q_mag) : q_mag;
    rem       = (is_signed && rs_E[31]) ? (32'd0 - r_mag) : r_mag;
  end
`endif

  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (MDUop)
      MDU_MULTU: result = prod_u;
      MDU_MULT:  result = prod_s;
`ifdef MDU_DIV_EN
      MDU_DIVU, MDU_DIV: begin
        result   = {rem, quot};
        div_zero = (rt_E == 32'd0);
      end
`endif
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// MDU scheduler: owns HI/LO, models fixed mult/div latency with a busy counter,
// and stalls MD-class instructions in D. Divide support is enabled by MDU_DIV_EN.
module mdu_sched
  import mdu_defs::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUop,
  input  logic        c_HIWE,
  input  logic        c_LOWE,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        c_MD_D,
  output logic        busy,
  output logic        stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_dz;
  mdu_state_t    state;

  logic [63:0]   arith_res;
  logic          arith_dz;
  logic          op_ok;
  logic [CW-1:0] lat_sel;

  mdu_arith u_arith (
    .MDUop    (MDUop),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .result   (arith_res),
    .div_zero (arith_dz)
  );

  always_comb begin
    op_ok   = 1'b0;
    lat_sel = CW'(MULT_LAT);
    case (MDUop)
      MDU_MULTU, MDU_MULT: op_ok = 1'b1;
`ifdef MDU_DIV_EN
      MDU_DIVU, MDU_DIV: begin
        op_ok   = 1'b1;
        lat_sel = CW'(DIV_LAT);
      end
`endif
      default: op_ok = 1'b0;
    endcase
  end

  // State is a view of the counter so checkers can bind to it directly.
  assign state    = (cnt != '0) ? ST_BUSY : ST_IDLE;
  assign busy     = (state == ST_BUSY);
  assign stall_MD = c_MD_D & (start | busy);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          // start takes priority; a coincident mthi/mtlo is dropped.
          if (start && op_ok) begin
            cnt     <= lat_sel;
            pend_hi <= arith_res[63:32];
            pend_lo <= arith_res[31:0];
            pend_dz <= arith_dz;
          end else begin
            if (c_HIWE) HI <= rs_E;
            if (c_LOWE) LO <= rs_E;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1) && !pend_dz) begin
            HI <= pend_hi;
            LO <= pend_lo;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: latency, stall window, HI/LO results,
// mthi/mtlo writes, priority rules and mid-operation reset.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDUop;
  logic        c_HIWE;
  logic        c_LOWE;
  logic [31:0] rs_E;
  logic [31:0] rt_E;
  logic        c_MD_D;
  logic        busy;
  logic        stall_MD;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_tests  = 0;
  int n_failed = 0;

  mdu_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .MDUop    (MDUop),
    .c_HIWE   (c_HIWE),
    .c_LOWE   (c_LOWE),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .c_MD_D   (c_MD_D),
    .busy     (busy),
    .stall_MD (stall_MD),
    .HI       (HI),
    .LO       (LO)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    MDUop = op;
    rs_E  = a;
    rt_E  = b;
    tick();
    start = 1'b0;
    rs_E  = 32'd0;
    rt_E  = 32'd0;
  endtask

  // Called in cycle T+1: checks busy for lat cycles, then idle at T+lat+1.
  task automatic wait_done(input string tag, input int lat);
    for (int i = 1; i <= lat; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    MDUop  = 3'b000;
    c_HIWE = 1'b0;
    c_LOWE = 1'b0;
    rs_E   = 32'd0;
    rt_E   = 32'd0;
    c_MD_D = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    c_MD_D = 1'b1;
    #1;
    check("rst_stall_idle", {31'd0, stall_MD}, 32'd0);
    start = 1'b1;
    MDUop = 3'b001;
    #1;
    check("rst_stall_start", {31'd0, stall_MD}, 32'd1);
    tick();
    check("rst_start_ignored", {31'd0, busy}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    tick();

    // mult -3*5 with stall window and a start+mthi during BUSY
    c_MD_D = 1'b1;
    start  = 1'b1;
    MDUop  = 3'b001;
    rs_E   = 32'hFFFF_FFFD;
    rt_E   = 32'd5;
    #1;
    check("mult_stall_T", {31'd0, stall_MD}, 32'd1);
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("mult_busy", {31'd0, busy}, 32'd1);
      check("mult_stall", {31'd0, stall_MD}, 32'd1);
      check("mult_hi_hold", HI, 32'd0);
      start  = (i == 2);
      c_HIWE = (i == 2);
      MDUop  = 3'b000;
      rs_E   = (i == 2) ? 32'd2 : 32'd0;
      rt_E   = (i == 2) ? 32'd3 : 32'd0;
      tick();
      start  = 1'b0;
      c_HIWE = 1'b0;
    end
    check("mult_busy_end", {31'd0, busy}, 32'd0);
    check("mult_stall_end", {31'd0, stall_MD}, 32'd0);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFF1);
    c_MD_D = 1'b0;

    // mtlo then mthi in IDLE
    c_LOWE = 1'b1;
    rs_E   = 32'h0000_1234;
    tick();
    c_LOWE = 1'b0;
    check("mtlo_lo", LO, 32'h0000_1234);
    check("mtlo_hi_keep", HI, 32'hFFFF_FFFF);
    c_HIWE = 1'b1;
    rs_E   = 32'h0000_ABCD;
    tick();
    c_HIWE = 1'b0;
    check("mthi_hi", HI, 32'h0000_ABCD);

    // start with coincident mtlo: the write is dropped
    c_LOWE = 1'b1;
    issue(3'b000, 32'd2, 32'd3);
    c_LOWE = 1'b0;
    check("prio_lo_keep", LO, 32'h0000_1234);
    wait_done("prio", 5);
    check("prio_hi", HI, 32'd0);
    check("prio_lo", LO, 32'd6);

    // multu max*max
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 5);
    check("multu_max_hi", HI, 32'hFFFF_FFFE);
    check("multu_max_lo", LO, 32'h0000_0001);

    // mult min*min
    issue(3'b001, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min", 5);
    check("mult_min_hi", HI, 32'h4000_0000);
    check("mult_min_lo", LO, 32'h0000_0000);

    // Invalid MDUop is a no-op
    issue(3'b100, 32'd9, 32'd9);
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", HI, 32'h4000_0000);

    // Reset at T+2 of a mult discards the result
    issue(3'b001, 32'd7, 32'd9);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    tick();
    tick();
    tick();
    tick();
    check("midrst_lo_later", LO, 32'd0);

`ifdef MDU_DIV_EN
    issue(3'b010, 32'd7, 32'd2);
    wait_done("divu", 10);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 10);
    check("div_neg_lo", LO, 32'hFFFF_FFFD);
    check("div_neg_hi", HI, 32'hFFFF_FFFF);

    c_LOWE = 1'b1;
    rs_E   = 32'h0000_1234;
    tick();
    c_LOWE = 1'b0;
    issue(3'b011, 32'd55, 32'd0);
    wait_done("div0", 10);
    check("div0_lo", LO, 32'h0000_1234);
    check("div0_hi", HI, 32'hFFFF_FFFF);

    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'd0);
`else
    issue(3'b010, 32'd7, 32'd2);
    check("nodiv_busy", {31'd0, busy}, 32'd0);
    tick();
    check("nodiv_lo", LO, 32'd0);
    check("nodiv_hi", HI, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
